// File: rtl/mem_access.sv
// mem_access: MEM pipeline stage. Runs req/ack data-bus cycles for loads/stores and passes other ops to WB.
// Define MEM_ALIGN_CHECK_EN to fault misaligned word accesses without starting a bus cycle.

module mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  mem_wd,
    input  logic        mem_wreg,
    input  logic [31:0] mem_wdata,
    input  logic [2:0]  mem_op,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_sdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [31:0] bus_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_wdata,
    output logic        stallreq,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        mem_fault
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic {
        IDLE,
        BUS
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            sext_q;
    logic            word_q;
    logic            load_q;
    logic [1:0]      off_q;

    logic            bus_req_q;
    logic            bus_we_q;
    logic [31:0]     bus_addr_q;
    logic [3:0]      bus_sel_q;
    logic [31:0]     bus_wdata_q;
    logic [4:0]      wb_wd_q;
    logic            wb_wreg_q;
    logic [31:0]     wb_wdata_q;
    logic            mem_fault_q;

    logic            op_load;
    logic            op_store;
    logic            op_word;
    logic            op_signed;
    logic            misaligned;
    logic            start;
    logic            timeout;
    logic [3:0]      sel_d;
    logic [31:0]     wdata_d;
    logic [7:0]      rbyte;
    logic [31:0]     ld_data_d;

    always_comb begin
        op_load   = 1'b0;
        op_store  = 1'b0;
        op_word   = 1'b0;
        op_signed = 1'b0;
        case (mem_op)
            3'b001: begin op_load  = 1'b1; op_signed = 1'b1; end
            3'b010: begin op_load  = 1'b1; end
            3'b011: begin op_load  = 1'b1; op_word   = 1'b1; end
            3'b100: begin op_store = 1'b1; end
            3'b101: begin op_store = 1'b1; op_word   = 1'b1; end
            default: ;
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = op_word && (mem_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign start   = (op_load | op_store) & ~misaligned;
    assign timeout = (cnt_q == CW'(TIMEOUT - 1));

    // Big-endian lanes: byte offset 0 lives in bits 31:24.
    assign sel_d   = op_word ? 4'b1111 : (4'b1000 >> mem_addr[1:0]);
    assign wdata_d = op_word ? mem_sdata : {4{mem_sdata[7:0]}};

    always_comb begin
        rbyte = '0;
        case (off_q)
            2'd0: rbyte = bus_rdata[31:24];
            2'd1: rbyte = bus_rdata[23:16];
            2'd2: rbyte = bus_rdata[15:8];
            2'd3: rbyte = bus_rdata[7:0];
            default: rbyte = '0;
        endcase
    end

    always_comb begin
        if (word_q) begin
            ld_data_d = bus_rdata;
        end else if (sext_q) begin
            ld_data_d = {{24{rbyte[7]}}, rbyte};
        end else begin
            ld_data_d = {24'h000000, rbyte};
        end
    end

    always_comb begin
        stallreq = 1'b0;
        case (state_q)
            IDLE:    stallreq = start;
            BUS:     stallreq = ~(bus_ack | bus_err | timeout);
            default: stallreq = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sext_q      <= 1'b0;
            word_q      <= 1'b0;
            load_q      <= 1'b0;
            off_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= '0;
            bus_wdata_q <= '0;
            wb_wd_q     <= '0;
            wb_wreg_q   <= 1'b0;
            wb_wdata_q  <= '0;
            mem_fault_q <= 1'b0;
        end else begin
            mem_fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= BUS;
                        cnt_q       <= '0;
                        sext_q      <= op_signed;
                        word_q      <= op_word;
                        load_q      <= op_load;
                        off_q       <= mem_addr[1:0];
                        bus_req_q   <= 1'b1;
                        bus_we_q    <= op_store;
                        bus_addr_q  <= {mem_addr[31:2], 2'b00};
                        bus_sel_q   <= sel_d;
                        bus_wdata_q <= wdata_d;
                        wb_wreg_q   <= 1'b0;
                    end else if (misaligned) begin
                        mem_fault_q <= 1'b1;
                        wb_wreg_q   <= 1'b0;
                    end else begin
                        wb_wd_q     <= mem_wd;
                        wb_wreg_q   <= mem_wreg;
                        wb_wdata_q  <= mem_wdata;
                    end
                end
                BUS: begin
                    // Error outranks a simultaneous ack; an ack on the last counted cycle still succeeds.
                    if (bus_err) begin
                        state_q     <= IDLE;
                        bus_req_q   <= 1'b0;
                        mem_fault_q <= 1'b1;
                        wb_wreg_q   <= 1'b0;
                    end else if (bus_ack) begin
                        state_q   <= IDLE;
                        bus_req_q <= 1'b0;
                        if (load_q) begin
                            wb_wd_q    <= mem_wd;
                            wb_wreg_q  <= mem_wreg;
                            wb_wdata_q <= ld_data_d;
                        end else begin
                            wb_wreg_q  <= 1'b0;
                        end
                    end else if (timeout) begin
                        state_q     <= IDLE;
                        bus_req_q   <= 1'b0;
                        mem_fault_q <= 1'b1;
                        wb_wreg_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_sel   = bus_sel_q;
    assign bus_wdata = bus_wdata_q;
    assign wb_wd     = wb_wd_q;
    assign wb_wreg   = wb_wreg_q;
    assign wb_wdata  = wb_wdata_q;
    assign mem_fault = mem_fault_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed cases plus randomized ops against a transaction-level model.
module tb_mem_access;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  mem_wd = '0;
    logic        mem_wreg = 1'b0;
    logic [31:0] mem_wdata = '0;
    logic [2:0]  mem_op = '0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_sdata = '0;
    logic        bus_ack = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_req, bus_we, stallreq, wb_wreg, mem_fault;
    logic [31:0] bus_addr, bus_wdata, wb_wdata;
    logic [3:0]  bus_sel;
    logic [4:0]  wb_wd;

    int nvec = 0;
    int nerr = 0;

    mem_access #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
        .bus_ack(bus_ack), .bus_err(bus_err), .bus_rdata(bus_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_sel(bus_sel), .bus_wdata(bus_wdata), .stallreq(stallreq),
        .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    function automatic bit m_word(input logic [2:0] op);
        return (op == 3'd3) || (op == 3'd5);
    endfunction

    function automatic logic [3:0] m_sel(input logic [2:0] op, input logic [31:0] a);
        logic [3:0] s;
        if (m_word(op)) return 4'hF;
        s = 4'b0001 << (3 - int'(a[1:0]));
        return s;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] sd);
        if (m_word(op)) return sd;
        return sd[7:0] * 32'h01010101;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] a, input logic [31:0] rd);
        int unsigned b;
        if (op == 3'd3) return rd;
        b = (rd / (32'd1 << (8 * (3 - int'(a[1:0]))))) % 256;
        if (op == 3'd1 && b >= 128) return 32'(b) - 32'd256;
        return 32'(b);
    endfunction

    function automatic bit m_misal(input logic [2:0] op, input logic [31:0] a);
`ifdef MEM_ALIGN_CHECK_EN
        return m_word(op) && (a[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // Entered and left at posedge+1.
    task automatic do_none(input logic [2:0] op, input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        mem_op = op; mem_wd = wd; mem_wreg = wreg; mem_wdata = wdata;
        mem_addr = $urandom; mem_sdata = $urandom;
        @(negedge clk);
        nvec++;
        if (stallreq !== 1'b0) begin
            nerr++; $display("FAIL none_stall op=%0d got=%b exp=0", op, stallreq);
        end
        @(posedge clk); #1;
        nvec++;
        if ({wb_wd, wb_wreg, wb_wdata, mem_fault, bus_req} !== {wd, wreg, wdata, 1'b0, 1'b0}) begin
            nerr++;
            $display("FAIL none_wb got wd=%0d wreg=%b data=%h fault=%b req=%b exp wd=%0d wreg=%b data=%h fault=0 req=0",
                     wb_wd, wb_wreg, wb_wdata, mem_fault, bus_req, wd, wreg, wdata);
        end
    endtask

    // kind: 0 silent, 1 ack, 2 err, 3 ack+err; response raised in BUS cycle 'lat'.
    task automatic do_mem(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int lat, input int kind,
                          input logic [4:0] wd, input logic wreg);
        bit resp, fault, load_ok;
        int term, stalls;
        resp    = (kind != 0) && (lat <= int'(TO) - 1);
        term    = resp ? lat : int'(TO) - 1;
        fault   = !resp || (kind >= 2);
        load_ok = resp && (kind == 1) && (op <= 3'd3);
        stalls  = 0;
        mem_op = op; mem_addr = addr; mem_sdata = sdata; mem_wd = wd; mem_wreg = wreg;
        mem_wdata = $urandom; bus_ack = 1'b0; bus_err = 1'b0;
        @(negedge clk);
        if (m_misal(op, addr)) begin
            nvec++;
            if ({stallreq, bus_req} !== 2'b00) begin
                nerr++; $display("FAIL misal_stall got stall=%b req=%b exp 0 0", stallreq, bus_req);
            end
            @(posedge clk); #1;
            nvec++;
            if ({mem_fault, wb_wreg, bus_req} !== 3'b100) begin
                nerr++; $display("FAIL misal_fault got fault=%b wreg=%b req=%b exp 1 0 0", mem_fault, wb_wreg, bus_req);
            end
            return;
        end
        nvec++;
        if ({stallreq, bus_req} !== 2'b10) begin
            nerr++; $display("FAIL idle_issue got stall=%b req=%b exp 1 0", stallreq, bus_req);
        end
        if (stallreq === 1'b1) stalls++;
        @(posedge clk); #1;
        for (int i = 0; i <= term; i++) begin
            nvec++;
            if (bus_req !== 1'b1) begin
                nerr++; $display("FAIL bus_req cyc=%0d got=%b exp=1", i, bus_req);
            end
            if (i == 0) begin
                nvec++;
                if ({bus_we, bus_addr, bus_sel, mem_fault, wb_wreg} !==
                    {op >= 3'd4, addr[31:2], 2'b00, m_sel(op, addr), 1'b0, 1'b0}) begin
                    nerr++;
                    $display("FAIL bus_fields got we=%b addr=%h sel=%b fault=%b wreg=%b exp we=%b addr=%h sel=%b fault=0 wreg=0",
                             bus_we, bus_addr, bus_sel, mem_fault, wb_wreg, op >= 3'd4, {addr[31:2], 2'b00}, m_sel(op, addr));
                end
                if (op >= 3'd4) begin
                    nvec++;
                    if (bus_wdata !== m_wdata(op, sdata)) begin
                        nerr++; $display("FAIL bus_wdata got=%h exp=%h", bus_wdata, m_wdata(op, sdata));
                    end
                end
            end
            if (resp && i == lat) begin
                bus_ack = (kind == 1) || (kind == 3);
                bus_err = (kind >= 2);
                bus_rdata = rdata;
            end else begin
                bus_rdata = $urandom;
            end
            @(negedge clk);
            nvec++;
            if (stallreq !== (i != term)) begin
                nerr++; $display("FAIL bus_stall cyc=%0d got=%b exp=%b", i, stallreq, i != term);
            end
            if (stallreq === 1'b1) stalls++;
            @(posedge clk); #1;
        end
        bus_ack = 1'b0; bus_err = 1'b0;
        nvec++;
        if (stalls != term + 1) begin
            nerr++; $display("FAIL stall_count got=%0d exp=%0d", stalls, term + 1);
        end
        nvec++;
        if ({bus_req, mem_fault, wb_wreg} !== {1'b0, fault, load_ok ? wreg : 1'b0}) begin
            nerr++;
            $display("FAIL term got req=%b fault=%b wreg=%b exp req=0 fault=%b wreg=%b",
                     bus_req, mem_fault, wb_wreg, fault, load_ok ? wreg : 1'b0);
        end
        if (load_ok) begin
            nvec++;
            if ({wb_wd, wb_wdata} !== {wd, m_load(op, addr, rdata)}) begin
                nerr++; $display("FAIL load_data got wd=%0d data=%h exp wd=%0d data=%h",
                                 wb_wd, wb_wdata, wd, m_load(op, addr, rdata));
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #2;
        nvec++;
        if ({bus_req, bus_we, bus_addr, bus_sel, bus_wdata, wb_wd, wb_wreg, wb_wdata, mem_fault, stallreq} !== '0) begin
            nerr++; $display("FAIL reset_vals req=%b we=%b addr=%h sel=%b wd=%0d wreg=%b fault=%b exp all 0",
                             bus_req, bus_we, bus_addr, bus_sel, wb_wd, wb_wreg, mem_fault);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_passthrough();
        do_none(3'd0, 5'd5, 1'b1, 32'h1234);
        for (int i = 0; i < 6; i++)
            do_none(3'($urandom_range(0, 1) == 0 ? 0 : $urandom_range(6, 7)), 5'($urandom), 1'($urandom), $urandom);
    endtask

    task automatic test_load_byte();
        do_mem(3'd1, 32'h101, 32'h0, 32'h00800000, 3, 1, 5'd7, 1'b1);
        do_mem(3'd2, 32'h101, 32'h0, 32'h00800000, 0, 1, 5'd8, 1'b1);
        do_mem(3'd3, 32'h200, 32'h0, 32'hDEADBEEF, 1, 1, 5'd9, 1'b1);
    endtask

    task automatic test_store_byte();
        do_mem(3'd4, 32'h103, 32'hAB, 32'h0, 2, 1, 5'd3, 1'b1);
        do_mem(3'd5, 32'h104, 32'hCAFEF00D, 32'h0, 0, 1, 5'd3, 1'b1);
    endtask

    task automatic test_timeout();
        do_mem(3'd3, 32'h300, 32'h0, 32'h0, 99, 0, 5'd4, 1'b1);
        do_mem(3'd3, 32'h304, 32'h0, 32'h11223344, int'(TO) - 1, 1, 5'd4, 1'b1);
    endtask

    task automatic test_err();
        do_mem(3'd1, 32'h400, 32'h0, 32'hFF000000, 1, 2, 5'd6, 1'b1);
        do_mem(3'd3, 32'h404, 32'h0, 32'h12345678, 0, 3, 5'd6, 1'b1);
    endtask

    task automatic test_align();
        do_mem(3'd5, 32'h2, 32'h55667788, 32'h0, 1, 1, 5'd2, 1'b1);
        do_mem(3'd3, 32'h3, 32'h0, 32'hA5A5A5A5, 0, 1, 5'd2, 1'b1);
        do_none(3'd0, 5'd1, 1'b1, 32'h77);
    endtask

    task automatic test_back_to_back();
        do_mem(3'd2, 32'h502, 32'h0, 32'h0000C300, 0, 1, 5'd10, 1'b1);
        do_mem(3'd4, 32'h500, 32'h5A, 32'h0, 0, 1, 5'd10, 1'b1);
        do_mem(3'd1, 32'h503, 32'h0, 32'h0000007F, 0, 1, 5'd11, 1'b1);
    endtask

    task automatic test_reset_mid();
        mem_op = 3'd3; mem_addr = 32'h600; mem_wd = 5'd12; mem_wreg = 1'b1;
        bus_ack = 1'b0; bus_err = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        nvec++;
        if (bus_req !== 1'b1) begin
            nerr++; $display("FAIL rst_mid_pre got req=%b exp=1", bus_req);
        end
        rst = 1'b0; mem_op = 3'd0;
        #1;
        nvec++;
        if ({bus_req, bus_we, bus_addr, bus_sel, bus_wdata, wb_wd, wb_wreg, wb_wdata, mem_fault, stallreq} !== '0) begin
            nerr++; $display("FAIL rst_mid got req=%b addr=%h sel=%b wreg=%b fault=%b stall=%b exp all 0",
                             bus_req, bus_addr, bus_sel, wb_wreg, mem_fault, stallreq);
        end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        do_none(3'd0, 5'd13, 1'b1, 32'hBEEF);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int r, lat, kind;
            r = $urandom_range(0, 9);
            if (r < 3) begin
                do_none(3'(r == 0 ? 7 : 0), 5'($urandom), 1'($urandom), $urandom);
            end else begin
                lat  = ($urandom_range(0, 7) == 0) ? int'(TO) + 2 : $urandom_range(0, 4);
                kind = ($urandom_range(0, 5) < 4) ? 1 : $urandom_range(0, 3);
                do_mem(3'($urandom_range(1, 5)), $urandom, $urandom, $urandom, lat, kind, 5'($urandom), 1'($urandom));
            end
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_load_byte();
        test_store_byte();
        test_timeout();
        test_err();
        test_align();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
